// File: rtl/alu_arb_pkg.sv
// Shared types for the round-robin ALU arbiter: FSM state encoding and ALU opcode values.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } arb_state_t;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_SHL  = 3'd5;
    localparam logic [2:0] OP_SHR  = 3'd6;
    localparam logic [2:0] OP_PASS = 3'd7;

endpackage

// File: rtl/alu_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping modulo N_REQ.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_idx,
    output logic             any_req
);

    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_req   = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, ptr} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(N_REQ)) begin
                sum = sum - (ID_W+1)'(N_REQ);
            end
            idx = sum[ID_W-1:0];
            if (!any_req && req[idx]) begin
                any_req    = 1'b1;
                grant_idx  = idx;
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among N_REQ requesters, one op in flight.
// Define ALU_ARB_STATS_EN to add saturating per-requester grant counters on grant_cnt.
module alu_rr_arbiter
    import alu_arb_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8,
    parameter int OP_W   = 3,
    localparam int ID_W  = $clog2(N_REQ)
`ifdef ALU_ARB_STATS_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*DATA_W-1:0] req_a,
    input  logic [N_REQ*DATA_W-1:0] req_b,
    input  logic [N_REQ*OP_W-1:0]   req_opcode,
    output logic [DATA_W-1:0]       alu_a,
    output logic [DATA_W-1:0]       alu_b,
    output logic [OP_W-1:0]         alu_opcode,
    input  logic [DATA_W-1:0]       alu_result,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_W-1:0]       rsp_data,
    output logic [ID_W-1:0]         rsp_id,
    output logic                    busy
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [N_REQ*CNT_W-1:0]  grant_cnt
`endif
);

    arb_state_t        state, state_nxt;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   gnt_id;
    logic [N_REQ-1:0]  grant;
    logic [ID_W-1:0]   pick_idx;
    logic              any_req;
    logic              accept;

    logic [DATA_W-1:0] a_arr  [N_REQ];
    logic [DATA_W-1:0] b_arr  [N_REQ];
    logic [OP_W-1:0]   op_arr [N_REQ];

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            a_arr[i]  = req_a[i*DATA_W +: DATA_W];
            b_arr[i]  = req_b[i*DATA_W +: DATA_W];
            op_arr[i] = req_opcode[i*OP_W +: OP_W];
        end
    end

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (pick_idx),
        .any_req   (any_req)
    );

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        req_ready = '0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                // Grant is only offered outside reset so a dropped op is never half-accepted.
                if (!reset) begin
                    req_ready = grant;
                    accept    = any_req;
                end
                if (any_req) state_nxt = ISSUE;
            end
            ISSUE:   state_nxt = CAPTURE;
            CAPTURE: state_nxt = RESP;
            RESP:    if (rsp_valid && rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            gnt_id     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_id     <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                alu_a      <= a_arr[pick_idx];
                alu_b      <= b_arr[pick_idx];
                alu_opcode <= op_arr[pick_idx];
                gnt_id     <= pick_idx;
            end
            if (state == CAPTURE) begin
                rsp_data  <= alu_result;
                rsp_id    <= gnt_id;
                rsp_valid <= 1'b1;
            end
            // Served requester drops to lowest priority for the next search.
            if (state == RESP && rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
                rr_ptr    <= (gnt_id == ID_W'(N_REQ-1)) ? '0 : gnt_id + ID_W'(1);
            end
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [CNT_W-1:0] cnt_q [N_REQ];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (accept && grant[i] && (cnt_q[i] != '1)) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_REQ; i++) grant_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
    end
`endif

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed scoreboard bench for alu_rr_arbiter with a behavioural ALU on the alu_* ports.
module tb_alu_rr_arbiter;
    import alu_arb_pkg::*;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int OW = 3;
    localparam int IW = 2;
    localparam int CW = 16;
    localparam int QD = 16;

    logic            clk, reset;
    logic [N-1:0]    req_valid, req_ready;
    logic [N*DW-1:0] req_a, req_b;
    logic [N*OW-1:0] req_opcode;
    logic [DW-1:0]   alu_a, alu_b, alu_result, rsp_data;
    logic [OW-1:0]   alu_opcode;
    logic            rsp_valid, rsp_ready, busy;
    logic [IW-1:0]   rsp_id;
`ifdef ALU_ARB_STATS_EN
    logic [N*CW-1:0] grant_cnt;
`endif

    alu_rr_arbiter #(.N_REQ(N), .DATA_W(DW), .OP_W(OW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_opcode (req_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .busy       (busy)
`ifdef ALU_ARB_STATS_EN
        ,
        .grant_cnt  (grant_cnt)
`endif
    );

    // Behavioural shared ALU.
    always_comb begin
        case (alu_opcode)
            OP_ADD:  alu_result = alu_a + alu_b;
            OP_SUB:  alu_result = alu_a - alu_b;
            OP_AND:  alu_result = alu_a & alu_b;
            OP_OR:   alu_result = alu_a | alu_b;
            OP_XOR:  alu_result = alu_a ^ alu_b;
            OP_SHL:  alu_result = alu_a << alu_b[2:0];
            OP_SHR:  alu_result = alu_a >> alu_b[2:0];
            default: alu_result = alu_a;
        endcase
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [IW-1:0] id;
        logic [DW-1:0] d;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;
    int   acc_cyc[$];

    logic [DW-1:0] qa [N][QD];
    logic [DW-1:0] qb [N][QD];
    logic [OW-1:0] qo [N][QD];
    int qh[N];
    int qn[N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected actual id=%0d data=%0h required=none", rsp_id, rsp_data);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_id", 32'(rsp_id), 32'(mon_e.id));
                chk("rsp_data", 32'(rsp_data), 32'(mon_e.d));
            end
        end
    end

    task automatic expect_rsp(input int id, input logic [DW-1:0] d);
        exp_t e;
        e.id = IW'(id);
        e.d  = d;
        sb.push_back(e);
    endtask

    task automatic set_req(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [OW-1:0] op);
        req_a[id*DW +: DW]      = a;
        req_b[id*DW +: DW]      = b;
        req_opcode[id*OW +: OW] = op;
    endtask

    task automatic load(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [OW-1:0] op);
        qa[id][qn[id]] = a;
        qb[id][qn[id]] = b;
        qo[id][qn[id]] = op;
        qn[id]++;
    endtask

    function automatic bit pending();
        bit p = 1'b0;
        for (int i = 0; i < N; i++) if (qh[i] < qn[i]) p = 1'b1;
        return p;
    endfunction

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            if (qh[i] < qn[i]) begin
                req_valid[i] = 1'b1;
                set_req(i, qa[i][qh[i]], qb[i][qh[i]], qo[i][qh[i]]);
            end else begin
                req_valid[i] = 1'b0;
            end
        end
    endtask

    // Requesters hold valid/payload until accepted, then advance to their next queued op.
    task automatic run_ops(input int budget);
        int n = 0;
        logic [N-1:0] acc;
        drive_reqs();
        while ((pending() || sb.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk);
            #1;
            n++;
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    qh[i]++;
                    acc_cyc.push_back(cyc);
                end
            end
            drive_reqs();
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL run_ops_timeout actual=%0d cycles required=<%0d", n, budget);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((sb.size() != 0 || busy) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL wait_idle_timeout actual=%0d cycles required=<%0d", n, budget);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset     = 1'b1;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int n;
        reset      = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_opcode = '0;
        rsp_ready  = 1'b1;
        for (int i = 0; i < N; i++) begin
            qh[i] = 0;
            qn[i] = 0;
        end

        // Reset values; requests during reset must not be acknowledged.
        repeat (3) @(posedge clk);
        #1;
        req_valid = 4'b1111;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_alu_a", 32'(alu_a), 32'h0);
        chk("rst_alu_b", 32'(alu_b), 32'h0);
        chk("rst_alu_opcode", 32'(alu_opcode), 32'h0);
        chk("rst_rsp_data", 32'(rsp_data), 32'h0);
        chk("rst_rsp_id", 32'(rsp_id), 32'h0);
        chk("rst_rr_ptr", 32'(dut.rr_ptr), 32'h0);
        @(posedge clk);
        #1;
        req_valid = '0;
        reset     = 1'b0;

        // 1: single request, latency to rsp_valid.
        set_req(0, 8'd15, 8'd10, OP_ADD);
        req_valid = 4'b0001;
        expect_rsp(0, 8'd25);
        @(negedge clk);
        chk("t1_ready", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        req_valid = '0;
        chk("t1_busy", 32'(busy), 32'h1);
        chk("t1_alu_a", 32'(alu_a), 32'd15);
        chk("t1_alu_b", 32'(alu_b), 32'd10);
        chk("t1_alu_op", 32'(alu_opcode), 32'(OP_ADD));
        chk("t1_ready_busy", 32'(req_ready), 32'h0);
        chk("t1_vld_t1", 32'(rsp_valid), 32'h0);
        @(posedge clk);
        #1;
        chk("t1_vld_t2", 32'(rsp_valid), 32'h0);
        @(posedge clk);
        #1;
        chk("t1_vld_t3", 32'(rsp_valid), 32'h1);
        @(posedge clk);
        #1;
        chk("t1_vld_after", 32'(rsp_valid), 32'h0);
        chk("t1_idle", 32'(busy), 32'h0);
        chk("t1_alu_a_kept", 32'(alu_a), 32'd15);

        // 2: all four requesters busy, grant order 0,1,2,3,0 at four cycles per op.
        do_reset();
        acc_cyc.delete();
        load(0, 8'd3, 8'd4, OP_ADD);
        load(0, 8'd100, 8'd1, OP_SUB);
        load(1, 8'hF0, 8'h3C, OP_AND);
        load(2, 8'h0F, 8'h30, OP_OR);
        load(3, 8'h81, 8'd2, OP_SHL);
        expect_rsp(0, 8'd7);
        expect_rsp(1, 8'h30);
        expect_rsp(2, 8'h3F);
        expect_rsp(3, 8'h04);
        expect_rsp(0, 8'd99);
        run_ops(200);
        chk("t2_accepts", 32'(acc_cyc.size()), 32'd5);
        if (acc_cyc.size() >= 5) chk("t2_spacing", 32'(acc_cyc[4] - acc_cyc[0]), 32'd16);

        // 3: back-pressure on the response, another requester waiting.
        rsp_ready = 1'b0;
        set_req(2, 8'h80, 8'd3, OP_SHR);
        req_valid = 4'b0100;
        expect_rsp(2, 8'h10);
        expect_rsp(1, 8'h00);
        @(negedge clk);
        chk("t3_ready2", 32'(req_ready), 32'h4);
        @(posedge clk);
        #1;
        set_req(1, 8'd5, 8'd5, OP_SUB);
        req_valid = 4'b0010;
        n = 0;
        while (!rsp_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t3_rsp_seen", 32'(rsp_valid), 32'h1);
        repeat (10) begin
            @(negedge clk);
            chk("t3_hold_data", 32'(rsp_data), 32'h10);
            chk("t3_hold_id", 32'(rsp_id), 32'd2);
            chk("t3_hold_ready", 32'(req_ready), 32'h0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("t3_idle_next", 32'(busy), 32'h0);
        chk("t3_vld_drop", 32'(rsp_valid), 32'h0);
        @(negedge clk);
        chk("t3_ready1", 32'(req_ready), 32'h2);
        @(posedge clk);
        #1;
        req_valid = '0;
        wait_idle(50);

        // 4: bring ptr to 3, then req1 and req3 together -> 3 wins, then 1.
        load(2, 8'd7, 8'd3, OP_XOR);
        expect_rsp(2, 8'd4);
        run_ops(50);
        chk("t4_ptr3", 32'(dut.rr_ptr), 32'd3);
        load(1, 8'd9, 8'd9, OP_PASS);
        load(3, 8'h55, 8'hAA, OP_OR);
        expect_rsp(3, 8'hFF);
        expect_rsp(1, 8'd9);
        run_ops(100);
        chk("t4_ptr_end", 32'(dut.rr_ptr), 32'd2);

        // 5: reset while capturing drops the operation.
        set_req(0, 8'd1, 8'd1, OP_ADD);
        req_valid = 4'b0001;
        @(posedge clk);
        #1;
        req_valid = '0;
        @(posedge clk);
        #1;
        chk("t5_in_capture", 32'(dut.state), 32'(CAPTURE));
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("t5_busy", 32'(busy), 32'h0);
        chk("t5_rr_ptr", 32'(dut.rr_ptr), 32'h0);
        reset = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("t5_no_rsp", 32'(rsp_valid), 32'h0);

`ifdef ALU_ARB_STATS_EN
        // 6: five ops from requester 1 only.
        do_reset();
        load(1, 8'd1, 8'd2, OP_ADD);
        load(1, 8'd10, 8'd3, OP_SUB);
        load(1, 8'hCC, 8'hAA, OP_AND);
        load(1, 8'h01, 8'd7, OP_SHL);
        load(1, 8'h42, 8'd0, OP_PASS);
        expect_rsp(1, 8'd3);
        expect_rsp(1, 8'd7);
        expect_rsp(1, 8'h88);
        expect_rsp(1, 8'h80);
        expect_rsp(1, 8'h42);
        run_ops(200);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("t6_cnt%0d", i), 32'(grant_cnt[i*CW +: CW]), (i == 1) ? 32'd5 : 32'd0);
        end
`endif

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
